// File: rtl/banco_reg_param.sv
// banco_reg_param: register bank with a hard zero register, an accumulator read port, write-to-read bypass and registered outputs
module banco_reg_param #(
  parameter int WIDTH   = 32,
  parameter int NREG    = 4,
  parameter int ACC_IDX = 2
) (
  input  logic                                  Clock,
  input  logic                                  Reset_n,
  input  logic                                  Escrita,
  input  logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0] IdReg,
  input  logic [WIDTH-1:0]                      Dado,
  input  logic                                  Leitura,
  input  logic                                  Flag_mem,
  input  logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0] Fonte1,
  input  logic [((NREG > 1) ? $clog2(NREG) : 1)-1:0] Fonte2,
  output logic [WIDTH-1:0]                      DadoLido1,
  output logic [WIDTH-1:0]                      DadoLido2,
  output logic                                  DadoValido
);
  localparam int AW = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [AW:0] ZERO_IDX = (AW+1)'(NREG - 1);
  localparam logic [AW-1:0] ACC = AW'(ACC_IDX);
  logic [WIDTH-1:0] mem [2**AW];
  logic [WIDTH-1:0] rd_acc, rd1, rd2;
  logic wr_ok;
  function automatic logic [WIDTH-1:0] rd(input logic [AW-1:0] i);
    return ({1'b0, i} < ZERO_IDX) ? ((Escrita && IdReg == i) ? Dado : mem[i]) : '0;
  endfunction
  // Read values per port: storage indices forward same-cycle write data, zero and out-of-range indices read 0
  always_comb begin
    wr_ok  = Escrita && ({1'b0, IdReg} < ZERO_IDX);
    rd_acc = rd(ACC);
    rd1    = rd(Fonte1);
    rd2    = rd(Fonte2);
  end
  // Storage write, registered reads and valid strobe; reset clears everything and dominates
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
      DadoLido1  <= '0;
      DadoLido2  <= '0;
      DadoValido <= 1'b0;
    end else begin
      if (wr_ok) mem[IdReg] <= Dado;
      if (Leitura) begin
        DadoLido1 <= Flag_mem ? rd1 : rd_acc;
        if (!Flag_mem) DadoLido2 <= rd2;
      end
      DadoValido <= Leitura;
    end
  end
endmodule
